cnt_sequencer: RTL and testbench
================================

// Module: cnt_sequencer
// PURPOSE
//  Control/sequencing front-end for the 8-bit counter datapath (cmpt) in tt_um_top.
//  Accepts commands over a valid/ready interface and drives the counter's enable, load and direction.
//  Commands configure the limit, prescale, direction and reload value, and start/stop one-shot or auto-reload runs.
//  Reads the counter value back, detects terminal count and raises a done pulse. Sits between ui_in decode and the counter.
// PARAMETERS
//  W        8   counter / data width
//  PSC_W    8   prescale register width (tick period = psc+1 clk cycles)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst           in   1      asynchronous reset, ACTIVE-LOW (0 = reset)
//  ena           in   1      design enable; 0 freezes FSM, prescaler and all regs (outputs hold)
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      command accepted when cmd_valid&cmd_ready at clk edge
//  cmd_op        in   3      opcode (see BEHAVIOUR)
//  cmd_data      in   W      operand
//  cmpt          in   W      current counter value (feedback from datapath)
//  cnt_en        out  1      1-cycle count strobe to counter
//  cnt_up        out  1      direction: 1 = up, 0 = down
//  cnt_load      out  1      1-cycle load strobe; counter takes cnt_load_val next edge
//  cnt_load_val  out  W      value to load (= reload register)
//  done          out  1      1-cycle pulse at terminal count
//  busy          out  1      1 while state is RUN
//  cmd_err       out  1      1-cycle pulse: accepted command illegal in current state
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; limit=all-ones; psc=0; reload=0; dir=up; mode=oneshot;
//   cnt_en=cnt_load=done=cmd_err=busy=0; cnt_up=1; cnt_load_val=0; prescaler=0.
//  Opcodes: 0 NOP | 1 SET_LIMIT limit<=data | 2 SET_PSC psc<=data[PSC_W-1:0] | 3 LOAD reload<=data, go LOAD
//   | 4 START_ONESHOT | 5 START_AUTO | 6 STOP | 7 SET_DIR dir<=data[0].
//  cmd_ready = (state!=LOAD) & ena. All ops are accepted in IDLE and DONE.
//  States:
//   IDLE: START_*: mode set, prescaler cleared, go RUN. LOAD: go LOAD. STOP: no-op.
//   LOAD: single cycle. cnt_load=1, cnt_load_val=reload, then return to IDLE.
//   RUN: prescaler counts 0..psc; tick when prescaler==psc, then wraps to 0. At tick:
//    - cmpt!=limit: cnt_en=1 for that cycle.
//    - cmpt==limit, oneshot: done=1, no cnt_en, go DONE.
//    - cmpt==limit, auto: done=1, cnt_load=1 (reload), stay RUN.
//    STOP: go IDLE immediately, no strobe that cycle even if tick coincides.
//    SET_LIMIT/SET_PSC/SET_DIR: accepted, effective from the next cycle.
//    LOAD or START_*: accepted, dropped, cmd_err=1.
//   DONE: behaves as IDLE (outputs idle); any START or LOAD leaves it.
//  Latency: command at edge N -> first registered strobe at N+1 earliest (psc=0: cnt_en every cycle in RUN).
//  Strobes are registered outputs; cnt_en and cnt_load are never both 1.
//  Comparison is exact equality, so wrap is the counter's modulo-2^W behaviour.
//   Down-count with limit>start reaches limit after wrap through 0.
//  ena=0 mid-RUN: prescaler/FSM hold and strobes forced 0. Resume on ena=1 with no lost or extra tick.
//  rst asserted mid-operation: immediate return to reset values, pending command lost.
// STRUCTURE
//  Shared package/header cnt_ctrl_pkg: opcode constants OP_*, state encoding ST_IDLE/LOAD/RUN/DONE, W default.
//  One sub-module, cnt_prescaler:
//   ports clk, rst, ena, clr, psc -> tick.
//   Free-running 0..psc counter, tick = (value==psc).
//  Top level: command decode + FSM + config regs, with all outputs registered.
// TESTING
//  1 Reset: rst=0 mid-RUN at psc=3 -> all outputs at reset values same cycle; busy=0, cnt_up=1.
//  2 LOAD 0x05 -> exactly one cnt_load with val 0x05 next cycle; cmd_ready=0 that cycle; back to IDLE.
//  3 limit=0x08, psc=2, cmpt from model starting 0x05, START_ONESHOT ->
//    cnt_en every 3rd cycle x3; done at cmpt=0x08; state DONE, busy=0.
//  4 Auto mode, reload=0x02, limit=0x04, psc=0 -> en,en,load,en,en,load...; done once per period; cnt_en&cnt_load never 1.
//  5 SET_DIR 0, reload=0x01, limit=0xFE, START_ONESHOT -> counts 01,00,FF,FE; done after 3 cnt_en.
//  6 In RUN: START_AUTO -> cmd_err pulse, mode unchanged.
//    STOP coincident with tick -> no strobe, IDLE.
//    ena=0 for 5 cycles -> tick spacing resumes unchanged.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared constants for the counter sequencer: opcodes, FSM state encoding,
// run mode and default widths.
package cnt_ctrl_pkg;

   localparam int W_DEF     = 8;
   localparam int PSC_W_DEF = 8;

   localparam logic [2:0] OP_NOP           = 3'd0;
   localparam logic [2:0] OP_SET_LIMIT     = 3'd1;
   localparam logic [2:0] OP_SET_PSC       = 3'd2;
   localparam logic [2:0] OP_LOAD          = 3'd3;
   localparam logic [2:0] OP_START_ONESHOT = 3'd4;
   localparam logic [2:0] OP_START_AUTO    = 3'd5;
   localparam logic [2:0] OP_STOP          = 3'd6;
   localparam logic [2:0] OP_SET_DIR       = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic {
      MODE_ONESHOT = 1'b0,
      MODE_AUTO    = 1'b1
   } mode_e;

   function automatic logic is_start(input logic [2:0] op);
      return (op == OP_START_ONESHOT) || (op == OP_START_AUTO);
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Free-running 0..psc divider; tick is high in the cycle the count equals psc.
module cnt_prescaler
   import cnt_ctrl_pkg::*;
#(
   parameter int PSC_W = PSC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clr,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   localparam logic [PSC_W-1:0] ONE = PSC_W'(1);

   logic [PSC_W-1:0] value_q, value_d;

   assign tick = (value_q == psc);

   // Wrapping on >= keeps the count bounded if psc is lowered mid-run.
   always_comb begin
      value_d = value_q + ONE;
      if (clr || (value_q >= psc)) begin
         value_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
      end else if (ena) begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/cnt_sequencer.sv
// Command-driven sequencer for the 8-bit counter datapath: config registers,
// IDLE/LOAD/RUN/DONE FSM and registered count/load/done strobes.
module cnt_sequencer
   import cnt_ctrl_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int PSC_W = PSC_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [W-1:0] cmd_data,
   input  logic [W-1:0] cmpt,
   output logic         cnt_en,
   output logic         cnt_up,
   output logic         cnt_load,
   output logic [W-1:0] cnt_load_val,
   output logic         done,
   output logic         busy,
   output logic         cmd_err
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     limit_q, limit_d;
   logic [W-1:0]     reload_q, reload_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             dir_q, dir_d;
   mode_e            mode_q, mode_d;
   logic             en_q, en_d;
   logic             load_q, load_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic             accept;
   logic             tick;
   logic             psc_clr;
   logic [W-1:0]     cmpt_eff;

   assign cmd_ready = (state_q != ST_LOAD) & ena;
   assign accept    = cmd_valid & cmd_ready;

   cnt_prescaler #(
      .PSC_W (PSC_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .clr  (psc_clr),
      .psc  (psc_q),
      .tick (tick)
   );

   // A strobe visible now has not reached cmpt yet; judge the value the
   // counter will hold once it lands, so psc=0 runs never overshoot.
   always_comb begin
      cmpt_eff = cmpt;
      if (load_q) begin
         cmpt_eff = reload_q;
      end else if (en_q) begin
         cmpt_eff = dir_q ? (cmpt + ONE) : (cmpt - ONE);
      end
   end

   always_comb begin
      state_d  = state_q;
      limit_d  = limit_q;
      reload_d = reload_q;
      psc_d    = psc_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      en_d     = 1'b0;
      load_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      psc_clr  = 1'b0;

      if (accept) begin
         case (cmd_op)
            OP_SET_LIMIT: limit_d = cmd_data;
            OP_SET_PSC:   psc_d   = cmd_data[PSC_W-1:0];
            OP_SET_DIR:   dir_d   = cmd_data[0];
            default:      ;
         endcase
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept && (cmd_op == OP_LOAD)) begin
               reload_d = cmd_data;
               load_d   = 1'b1;
               state_d  = ST_LOAD;
            end else if (accept && is_start(cmd_op)) begin
               mode_d  = (cmd_op == OP_START_AUTO) ? MODE_AUTO : MODE_ONESHOT;
               psc_clr = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (accept && (cmd_op == OP_STOP)) begin
               state_d = ST_IDLE;
            end else begin
               if (accept && ((cmd_op == OP_LOAD) || is_start(cmd_op))) begin
                  err_d = 1'b1;
               end
               if (tick) begin
                  if (cmpt_eff != limit_q) begin
                     en_d = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     if (mode_q == MODE_AUTO) begin
                        load_d = 1'b1;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         limit_q  <= '1;
         reload_q <= '0;
         psc_q    <= '0;
         dir_q    <= 1'b1;
         mode_q   <= MODE_ONESHOT;
         en_q     <= 1'b0;
         load_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         limit_q  <= limit_d;
         reload_q <= reload_d;
         psc_q    <= psc_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         en_q     <= en_d;
         load_q   <= load_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   // Held strobes are masked while frozen and reappear on resume, so no tick is lost.
   assign cnt_en       = en_q & ena;
   assign cnt_load     = load_q & ena;
   assign done         = done_q & ena;
   assign cmd_err      = err_q & ena;
   assign cnt_up       = dir_q;
   assign cnt_load_val = reload_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_cnt_sequencer.sv
// Self-checking bench for cnt_sequencer: a counter datapath model closes the
// cmpt loop and each scenario predicts strobe timing from psc, limit and start.
module tb_cnt_sequencer;

   localparam logic [2:0] OP_SET_LIMIT = 3'd1;
   localparam logic [2:0] OP_SET_PSC   = 3'd2;
   localparam logic [2:0] OP_LOAD      = 3'd3;
   localparam logic [2:0] OP_ONESHOT   = 3'd4;
   localparam logic [2:0] OP_AUTO      = 3'd5;
   localparam logic [2:0] OP_STOP      = 3'd6;
   localparam logic [2:0] OP_SET_DIR   = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic [7:0] cmpt;
   logic       cmd_ready, cnt_en, cnt_up, cnt_load, done, busy, cmd_err;
   logic [7:0] cnt_load_val;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int both_cnt = 0;
   int en_q[$];
   int ld_q[$];
   int dn_q[$];
   int er_q[$];

   always #5 clk = ~clk;

   cnt_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .cmpt         (cmpt),
      .cnt_en       (cnt_en),
      .cnt_up       (cnt_up),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .done         (done),
      .busy         (busy),
      .cmd_err      (cmd_err)
   );

   // Counter datapath model
   always @(posedge clk or negedge rst) begin
      if (!rst) cmpt <= 8'd0;
      else if (cnt_load) cmpt <= cnt_load_val;
      else if (cnt_en) cmpt <= cnt_up ? cmpt + 8'd1 : cmpt - 8'd1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cnt_en) en_q.push_back(cyc);
      if (cnt_load) ld_q.push_back(cyc);
      if (done) dn_q.push_back(cyc);
      if (cmd_err) er_q.push_back(cyc);
      if (cnt_en && cnt_load) both_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      en_q.delete();
      ld_q.delete();
      dn_q.delete();
      er_q.delete();
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] d);
      int guard;
      guard = 0;
      cmd_op = op;
      cmd_data = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && guard < 50) begin
         tick_n(1);
         guard++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL send_ready_timeout op=%0d ready=%0b required 1", op, cmd_ready);
      end
      tick_n(1);
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      int g;
      g = 0;
      while (dn_q.size() == 0 && g < bound) begin
         tick_n(1);
         g++;
      end
      ok = (dn_q.size() > 0);
   endtask

   task automatic test_reset();
      int n, r;
      bit ok;
      tick_n(2);
      tests++;
      if ({cnt_en, cnt_load, done, cmd_err, busy, cnt_up, cmd_ready} !== 7'b0000011 || cnt_load_val !== 8'h00) begin
         fails++;
         $display("FAIL reset_initial en/ld/dn/err/busy/up/rdy=%b val=%h required 0000011 val=00",
                  {cnt_en, cnt_load, done, cmd_err, busy, cnt_up, cmd_ready}, cnt_load_val);
      end
      rst = 1'b1;
      tick_n(1);
      send(OP_SET_DIR, 8'h00);
      send(OP_SET_PSC, 8'd3);
      send(OP_LOAD, 8'h33);
      send(OP_AUTO, 8'h00);
      r = $urandom_range(3, 9);
      tick_n(r);
      rst = 1'b0;
      #1;
      tests++;
      if ({cnt_en, cnt_load, done, cmd_err, busy, cnt_up} !== 6'b000001 || cnt_load_val !== 8'h00) begin
         fails++;
         $display("FAIL reset_midrun en/ld/dn/err/busy/up=%b val=%h required 000001 val=00",
                  {cnt_en, cnt_load, done, cmd_err, busy, cnt_up}, cnt_load_val);
      end
      tick_n(2);
      rst = 1'b1;
      tick_n(1);
      // Reset config: psc=0, up, limit=FF -> FC needs 3 strobes
      send(OP_LOAD, 8'hFC);
      send(OP_ONESHOT, 8'h00);
      n = cyc;
      clear_log();
      wait_done(20, ok);
      tests++;
      if (!ok || en_q.size() != 3 || dn_q[0] != n + 4) begin
         fails++;
         $display("FAIL reset_defaults done=%0b en_count=%0d done_cyc=%0d required 1 3 %0d",
                  ok, en_q.size(), ok ? dn_q[0] - n : -1, 4);
      end
      $display("[TB] reset checks done (release after %0d cycles in run)", r);
   endtask

   task automatic test_load();
      clear_log();
      send(OP_LOAD, 8'h05);
      tests++;
      if (cnt_load !== 1'b1 || cnt_load_val !== 8'h05 || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL load_strobe ld=%b val=%h rdy=%b required 1 05 0", cnt_load, cnt_load_val, cmd_ready);
      end
      tick_n(1);
      tests++;
      if (cnt_load !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || cmpt !== 8'h05) begin
         fails++;
         $display("FAIL load_after ld=%b rdy=%b busy=%b cmpt=%h required 0 1 0 05", cnt_load, cmd_ready, busy, cmpt);
      end
      tick_n(3);
      tests++;
      if (ld_q.size() != 1 || en_q.size() != 0) begin
         fails++;
         $display("FAIL load_count loads=%0d ens=%0d required 1 0", ld_q.size(), en_q.size());
      end
      $display("[TB] LOAD 0x05 checked");
   endtask

   task automatic run_oneshot(input logic [7:0] start, input logic [7:0] limit,
                              input logic [7:0] psc, input logic dir, input string tag);
      logic [7:0] diff;
      int k, n, p, bad;
      bit ok;
      diff = dir ? (limit - start) : (start - limit);
      k = int'(diff);
      p = int'(psc) + 1;
      send(OP_SET_DIR, {7'd0, dir});
      send(OP_SET_PSC, psc);
      send(OP_SET_LIMIT, limit);
      send(OP_LOAD, start);
      send(OP_ONESHOT, 8'h00);
      n = cyc;
      clear_log();
      wait_done((k + 2) * p + 10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_done_seen got 0 required 1", tag);
      end
      tests++;
      if (en_q.size() != k) begin
         fails++;
         $display("FAIL %s_en_count got %0d required %0d", tag, en_q.size(), k);
      end
      bad = -1;
      foreach (en_q[i]) if (bad < 0 && en_q[i] != n + (i + 1) * p) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s_en_timing idx=%0d got cyc+%0d required cyc+%0d", tag, bad, en_q[bad] - n, (bad + 1) * p);
      end
      tests++;
      if (ok && dn_q[0] != n + (k + 1) * p) begin
         fails++;
         $display("FAIL %s_done_timing got cyc+%0d required cyc+%0d", tag, dn_q[0] - n, (k + 1) * p);
      end
      tick_n(3);
      tests++;
      if (busy !== 1'b0 || cmpt !== limit || dn_q.size() != 1 || ld_q.size() != 0 || cnt_up !== dir) begin
         fails++;
         $display("FAIL %s_end busy=%b cmpt=%h dones=%0d loads=%0d up=%b required 0 %h 1 0 %b",
                  tag, busy, cmpt, dn_q.size(), ld_q.size(), cnt_up, limit, dir);
      end
      $display("[TB] %s oneshot start=%h limit=%h psc=%0d dir=%0d strobes=%0d", tag, start, limit, psc, dir, k);
   endtask

   task automatic run_auto(input logic [7:0] reload, input logic [7:0] limit,
                           input logic [7:0] psc, input int periods, input string tag);
      logic [7:0] diff;
      int k, n, p, per, t;
      int exp_en[$];
      int exp_ld[$];
      diff = limit - reload;
      k = int'(diff);
      p = int'(psc) + 1;
      per = k + 1;
      t = periods * per;
      for (int j = 1; j <= t; j++) begin
         if (j % per == 0) exp_ld.push_back(n_dummy(j));
      end
      exp_ld.delete();
      send(OP_SET_DIR, 8'h01);
      send(OP_SET_PSC, psc);
      send(OP_SET_LIMIT, limit);
      send(OP_LOAD, reload);
      send(OP_AUTO, 8'h00);
      n = cyc;
      clear_log();
      for (int j = 1; j <= t; j++) begin
         if (j % per == 0) exp_ld.push_back(n + j * p);
         else exp_en.push_back(n + j * p);
      end
      tick_n(t * p);
      send(OP_STOP, 8'h00);
      tick_n(2);
      tests++;
      if (en_q != exp_en) begin
         fails++;
         $display("FAIL %s_en_seq got %0d strobes required %0d", tag, en_q.size(), exp_en.size());
      end
      tests++;
      if (ld_q != exp_ld) begin
         fails++;
         $display("FAIL %s_load_seq got %0d loads required %0d", tag, ld_q.size(), exp_ld.size());
      end
      tests++;
      if (dn_q != exp_ld) begin
         fails++;
         $display("FAIL %s_done_seq got %0d dones required %0d", tag, dn_q.size(), exp_ld.size());
      end
      tests++;
      if (both_cnt != 0 || busy !== 1'b0 || cmpt !== reload) begin
         fails++;
         $display("FAIL %s_end both=%0d busy=%b cmpt=%h required 0 0 %h", tag, both_cnt, busy, cmpt, reload);
      end
      $display("[TB] %s auto reload=%h limit=%h psc=%0d periods=%0d", tag, reload, limit, psc, periods);
   endtask

   function automatic int n_dummy(input int j);
      return j;
   endfunction

   task automatic test_oneshot();
      logic [7:0] s, l, ps;
      logic d;
      int k;
      run_oneshot(8'h05, 8'h08, 8'd2, 1'b1, "t3");
      run_oneshot(8'h01, 8'hFE, 8'd0, 1'b0, "t5");
      run_oneshot(8'h40, 8'h40, 8'd1, 1'b1, "equal");
      for (int i = 0; i < 4; i++) begin
         s = 8'($urandom);
         k = $urandom_range(1, 10);
         d = 1'($urandom_range(0, 1));
         ps = 8'($urandom_range(0, 3));
         l = d ? s + 8'(k) : s - 8'(k);
         run_oneshot(s, l, ps, d, "rand");
      end
   endtask

   task automatic test_auto();
      logic [7:0] r;
      run_auto(8'h02, 8'h04, 8'd0, 3, "t4");
      r = 8'($urandom);
      run_auto(r, r + 8'($urandom_range(1, 5)), 8'($urandom_range(0, 2)), 2, "rand");
   endtask

   task automatic test_run_cmds();
      int n, j, p;
      bit ok;
      // Illegal commands in RUN
      p = 2;
      send(OP_SET_DIR, 8'h01);
      send(OP_SET_PSC, 8'd1);
      send(OP_SET_LIMIT, 8'h16);
      send(OP_LOAD, 8'h10);
      send(OP_ONESHOT, 8'h00);
      n = cyc;
      clear_log();
      tick_n(3);
      send(OP_AUTO, 8'h00);
      tests++;
      if (cmd_err !== 1'b1) begin
         fails++;
         $display("FAIL err_start_in_run got %b required 1", cmd_err);
      end
      send(OP_LOAD, 8'h77);
      tests++;
      if (cmd_err !== 1'b1 || cnt_load_val !== 8'h10 || cnt_load !== 1'b0) begin
         fails++;
         $display("FAIL err_load_in_run err=%b val=%h ld=%b required 1 10 0", cmd_err, cnt_load_val, cnt_load);
      end
      wait_done(40, ok);
      tick_n(3);
      tests++;
      if (!ok || er_q.size() != 2 || en_q.size() != 6 || dn_q[0] != n + 7 * p || ld_q.size() != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL err_mode_kept done=%0b errs=%0d ens=%0d loads=%0d busy=%b required 1 2 6 0 0",
                  ok, er_q.size(), en_q.size(), ld_q.size(), busy);
      end
      // STOP landing on a tick edge
      j = $urandom_range(1, 4);
      send(OP_SET_PSC, 8'd3);
      send(OP_SET_LIMIT, 8'h30);
      send(OP_LOAD, 8'h1C);
      send(OP_ONESHOT, 8'h00);
      clear_log();
      tick_n(4 * j - 1);
      send(OP_STOP, 8'h00);
      tests++;
      if (cnt_en !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL stop_on_tick en=%b busy=%b required 0 0", cnt_en, busy);
      end
      tick_n(8);
      tests++;
      if (en_q.size() != j - 1 || cmpt !== 8'h1C + 8'(j - 1)) begin
         fails++;
         $display("FAIL stop_after ens=%0d cmpt=%h required %0d %h", en_q.size(), cmpt, j - 1, 8'h1C + 8'(j - 1));
      end
      $display("[TB] RUN command errors and STOP at tick %0d checked", j);
   endtask

   task automatic test_ena_freeze();
      int n, f, r, p;
      int exp_en[$];
      bit ok;
      p = 2;
      send(OP_SET_DIR, 8'h01);
      send(OP_SET_PSC, 8'd1);
      send(OP_SET_LIMIT, 8'h58);
      send(OP_LOAD, 8'h50);
      send(OP_ONESHOT, 8'h00);
      n = cyc;
      clear_log();
      r = $urandom_range(1, 14);
      f = n + r;
      for (int j = 1; j <= 8; j++) exp_en.push_back((n + j * p >= f) ? n + j * p + 5 : n + j * p);
      tick_n(r);
      ena = 1'b0;
      tick_n(2);
      tests++;
      if (cmd_ready !== 1'b0 || cnt_en !== 1'b0) begin
         fails++;
         $display("FAIL ena_frozen rdy=%b en=%b required 0 0", cmd_ready, cnt_en);
      end
      tick_n(3);
      ena = 1'b1;
      wait_done(40, ok);
      tests++;
      if (en_q != exp_en) begin
         fails++;
         $display("FAIL ena_en_seq got %0d strobes (first cyc+%0d) required %0d", en_q.size(),
                  en_q.size() > 0 ? en_q[0] - n : -1, exp_en.size());
      end
      tests++;
      if (!ok || dn_q[0] != ((n + 9 * p >= f) ? n + 9 * p + 5 : n + 9 * p)) begin
         fails++;
         $display("FAIL ena_done_timing got cyc+%0d required cyc+%0d", ok ? dn_q[0] - n : -1,
                  (n + 9 * p >= f) ? 9 * p + 5 : 9 * p);
      end
      tick_n(2);
      tests++;
      if (cmpt !== 8'h58 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ena_end cmpt=%h busy=%b required 58 0", cmpt, busy);
      end
      $display("[TB] ena low for 5 cycles from cyc+%0d checked", r);
   endtask

   initial begin
      test_reset();
      test_load();
      test_oneshot();
      test_auto();
      test_run_cmds();
      test_ena_freeze();
      tests++;
      if (both_cnt != 0) begin
         fails++;
         $display("FAIL en_and_load_together got %0d required 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
